// File: rtl/rr_stream_mux_if.sv
// rr_stream_mux_if: producer-side channels and consumer-side output of the stream mux.
interface rr_stream_mux_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_valid;
    logic                    out_ready;
    modport master (output in_data, in_valid, mode, sel, out_ready,
                    input  in_ready, out_data, out_src, out_valid);
    modport slave  (input  in_data, in_valid, mode, sel, out_ready,
                    output in_ready, out_data, out_src, out_valid);
endinterface

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: registered N-to-1 valid/ready mux, fixed-select or round-robin arbitration.
module rr_stream_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input logic clk,
    input logic rst,
    rr_stream_mux_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_IN);
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] idx;
    logic             hit;
    logic             load_en;
    logic             xfer;
    always_comb begin
        hit = 1'b0;
        idx = '0;
        if (!bus.mode) begin
            hit = (int'(bus.sel) < NUM_IN) && bus.in_valid[bus.sel];
            idx = bus.sel;
        end else begin
            // descending scan so the channel closest to rr_ptr wins
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                if (bus.in_valid[(int'(rr_ptr) + k) % NUM_IN]) begin
                    hit = 1'b1;
                    idx = SEL_W'((int'(rr_ptr) + k) % NUM_IN);
                end
            end
        end
    end
    assign load_en      = !bus.out_valid || bus.out_ready;
    assign xfer         = hit && load_en;
    assign bus.in_ready = (xfer && !rst) ? (NUM_IN'(1) << idx) : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            rr_ptr        <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data[int'(idx)*WIDTH +: WIDTH];
            bus.out_src   <= idx;
            if (bus.mode)
                rr_ptr <= (int'(idx) == NUM_IN - 1) ? '0 : idx + 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised, registered N-to-1 data multiplexer with valid/ready handshakes on every input and on the output.
- Selects either a fixed channel (mode 0) or arbitrates round-robin among valid channels (mode 1).
- Latches the winner into a single-entry output register.
- Sits between multiple producers (operand/writeback sources, load return paths) and one consumer in the RISC pipeline, replacing bare combinational 2:1 muxes where flow control is needed.

Parameters:
- WIDTH, 32, data width per channel in bits.
- NUM_IN, 4, number of input channels; must be at least 2.
- SEL_W, derived localparam = clog2(NUM_IN), width of the channel index; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; at most one bit is high in any cycle.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in mode 0.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_src=0, round-robin pointer rr_ptr=0. in_ready is forced to all zeros while rst is high.
- Output register states:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - load_en = !out_valid | out_ready.
- Grant:
  - Combinational from in_valid, mode, sel and rr_ptr; one-hot or zero.
  - in_ready[i] = grant[i] & load_en.
  - A transfer on channel i occurs when in_valid[i] & in_ready[i].
- Mode 0 grant: grant[sel] = in_valid[sel]. If sel >= NUM_IN, there is no grant, no transfer, and no error.
- Mode 1 grant: the first valid channel searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_IN.
- Transfer on channel i: at the next edge out_data <= channel i data, out_src <= i, out_valid <= 1.
- No transfer while out_valid & out_ready: out_valid <= 0. out_data and out_src keep their values.
- FULL and !out_ready: out_data, out_src and out_valid stay stable; all in_ready bits are 0.
- Timing:
  - Latency is 1 cycle from input transfer to out_valid.
  - Throughput is 1 beat/cycle when out_ready is held high (a simultaneous drain and load is allowed).
- rr_ptr update:
  - After a transfer on channel i in mode 1, rr_ptr <= (i+1) mod NUM_IN. Channel NUM_IN-1 wraps to 0.
  - rr_ptr is unchanged by mode-0 transfers and by cycles with no transfer.
- Mode or sel changes take effect on the same cycle's grant; they never alter a beat already held in the output register.
- Reset mid-operation discards the held beat immediately (out_valid falls asynchronously). The input beat offered in that cycle is not consumed.
- Inputs must hold data stable while valid & !ready. The block does not check this.

Test Plan:
- Reset, then mode 0, sel=1, in_valid=4'b0010, ch1=32'h12345678, out_ready=1 -> in_ready=4'b0010; the next cycle out_valid=1, out_data=32'h12345678, out_src=1.
- Mode 1, all four channels valid continuously (ch i = 32'hA000_000i), out_ready=1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles; exactly one in_ready bit high per cycle.
- Backpressure: out_valid=1 holding 32'h87654321, out_ready=0 for 3 cycles with ch2 valid -> out_data unchanged and in_ready=0 throughout. out_ready=1 -> ch2 data appears the following cycle.
- Mode 1 with only ch3 valid and rr_ptr=3, one transfer -> rr_ptr wraps to 0. Then only ch1 and ch3 valid -> ch1 is granted before ch3.
- Mode 0, sel=1, ch1 not valid, ch0 valid -> no grant, in_ready=0, out_valid falls after the pending beat drains.
- Assert rst mid-stream with out_valid=1 -> out_valid, out_data and out_src go to 0 without waiting for a clock edge. After release, mode 1 arbitration restarts from ch0.
